pwm_output_stage: RTL and testbench

PWM_OUTPUT_STAGE -- requirements
Module: pwm_output_stage

---
 rtl/pwm_pkg.sv | 26 ++
 rtl/pwm_prescaler.sv | 30 +++
 rtl/pwm_output_stage.sv | 79 +++++++
 tb/tb_pwm_output_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared widths, constants, channel configuration type and compare helper for the PWM output stage.
package pwm_pkg;

    localparam int unsigned PWM_CNT_W = 8;
    localparam int unsigned NUM_CH    = 16;
    localparam int unsigned HALF_CH   = NUM_CH / 2;
    localparam int unsigned PRESC_W   = 16;

    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
    localparam logic [PWM_CNT_W-1:0] CNT_MAX   = 8'hFF;

    // Per-channel enable and mode-select vectors, bit i belongs to channel i.
    typedef struct packed {
        logic [NUM_CH-1:0] en_out;
        logic [NUM_CH-1:0] en_pwm;
    } ch_cfg_t;

    // Raw PWM level: full-scale duty never drops low, so the wrap back to 0 cannot glitch.
    function automatic logic pwm_compare(
        input logic [PWM_CNT_W-1:0] cnt,
        input logic [PWM_CNT_W-1:0] duty
    );
        return (duty == DUTY_FULL) || (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: counts 0..CLK_DIV-1 and flags the terminal count as the PWM tick.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_DIV = 13
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [PRESC_W-1:0] LAST = PRESC_W'(CLK_DIV - 1);

    logic [PRESC_W-1:0] cnt;

    // Tick is decoded from the count register; with CLK_DIV=1 the count stays 0 and tick is constant.
    assign tick = (cnt == LAST);

    // Free-running divider count, restarting at 0 after the terminal value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/pwm_output_stage.sv
// Sixteen-channel output stage: shared PWM counter with period-aligned duty shadow, per-channel enable/mode gating.
module pwm_output_stage
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_DIV = 13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [HALF_CH-1:0]   en_reg_out_7_0,
    input  logic [HALF_CH-1:0]   en_reg_out_15_8,
    input  logic [HALF_CH-1:0]   en_reg_pwm_7_0,
    input  logic [HALF_CH-1:0]   en_reg_pwm_15_8,
    input  logic [PWM_CNT_W-1:0] pwm_duty_cycle,
    output logic [NUM_CH-1:0]    out,
    output logic                 period_start
);

    ch_cfg_t              cfg;
    logic                 tick;
    logic                 wrap;
    logic                 wrap_d;
    logic                 raw_pwm;
    logic [PWM_CNT_W-1:0] cnt;
    logic [PWM_CNT_W-1:0] shadow;

    assign cfg.en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign cfg.en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    pwm_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // The tick that rolls the counter from 0xFF to 0x00 is the period boundary.
    assign wrap    = tick && (cnt == CNT_MAX);
    assign raw_pwm = pwm_compare(cnt, shadow);

    // Shared 8-bit PWM counter, advancing once per prescaler tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + PWM_CNT_W'(1);
        end
    end

    // Duty shadow only updates at the period boundary so a running period is never disturbed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (wrap) begin
            shadow <= pwm_duty_cycle;
        end
    end

    // Registered channel outputs: enable gates everything, mode selects PWM or static high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= cfg.en_out & (~cfg.en_pwm | {NUM_CH{raw_pwm}});
        end
    end

    // Period marker delayed twice so it lines up with the first output cycle showing counter 0x00.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_d       <= 1'b0;
            period_start <= 1'b0;
        end else begin
            wrap_d       <= wrap;
            period_start <= wrap_d;
        end
    end

endmodule

// File: tb/tb_pwm_output_stage.sv
// Scoreboard bench for pwm_output_stage with CLK_DIV=4 (1024-clk period).
module tb_pwm_output_stage;

    localparam int unsigned DIV    = 4;
    localparam int             PERIOD = 256 * DIV;
    localparam int             PS_BUDGET = 3000;

    typedef struct {
        int          due;
        logic [15:0] out_exp;
        logic        ps_exp;
        logic        chk_out;
        logic        chk_ps;
        string       name;
    } samp_t;

    typedef struct {
        int          len;
        int          high;
        logic [15:0] mask;
        logic [15:0] stat;
        string       name;
    } per_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] en_out = '0;
    logic [15:0] en_pwm = '0;
    logic [7:0]  duty = '0;
    logic [15:0] out;
    logic        period_start;

    samp_t       samp_q[$];
    per_t        exp_q[$];
    logic [15:0] win_q[$];

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int ps_count = 0;

    pwm_output_stage #(
        .CLK_DIV (DIV)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty),
        .out             (out),
        .period_start    (period_start)
    );

    always #5 clk = ~clk;

    // Monitor: cycle-tagged sample checks plus per-period window checks at each period_start.
    always @(negedge clk) begin
        samp_t s;
        per_t  e;
        int    hi;
        int    bad;
        logic [15:0] pm;
        cyc = cyc + 1;
        while (samp_q.size() > 0 && samp_q[0].due <= cyc) begin
            s = samp_q.pop_front();
            if (s.chk_out) begin
                checks++;
                if (out !== s.out_exp) begin
                    fails++;
                    $display("FAIL %s: out=%h expected %h (cycle %0d)", s.name, out, s.out_exp, cyc);
                end
            end
            if (s.chk_ps) begin
                checks++;
                if (period_start !== s.ps_exp) begin
                    fails++;
                    $display("FAIL %s: period_start=%b expected %b (cycle %0d)", s.name, period_start, s.ps_exp, cyc);
                end
            end
        end
        if (period_start === 1'b1) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                hi = 0;
                bad = 0;
                foreach (win_q[i]) begin
                    pm = win_q[i] & e.mask;
                    if (pm == e.mask) hi++;
                    if ((pm != 16'h0000 && pm != e.mask) || ((win_q[i] & ~e.mask) != e.stat)) bad++;
                end
                checks += 3;
                if (win_q.size() != e.len) begin
                    fails++;
                    $display("FAIL %s_len: period=%0d clk expected %0d", e.name, win_q.size(), e.len);
                end
                if (hi != e.high) begin
                    fails++;
                    $display("FAIL %s_high: high=%0d clk expected %0d", e.name, hi, e.high);
                end
                if (bad != 0) begin
                    fails++;
                    $display("FAIL %s_shape: %0d bad cycles expected 0", e.name, bad);
                end
            end
            win_q.delete();
            ps_count = ps_count + 1;
        end
        win_q.push_back(out);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_samp(input int due, input logic [15:0] o, input logic ps,
                             input logic co, input logic cp, input string name);
        samp_t s;
        s.due = due;
        s.out_exp = o;
        s.ps_exp = ps;
        s.chk_out = co;
        s.chk_ps = cp;
        s.name = name;
        samp_q.push_back(s);
    endtask

    task automatic wait_ps();
        int start;
        int n;
        start = ps_count;
        n = 0;
        while (ps_count == start && n < PS_BUDGET) begin
            step(1);
            n++;
        end
        if (ps_count == start) begin
            checks++;
            fails++;
            $display("FAIL wait_period_start: no pulse within %0d clk", n);
        end
    endtask

    task automatic expect_periods(input int n, input int high, input logic [15:0] mask,
                                  input logic [15:0] stat, input string name);
        for (int k = 0; k < n; k++) begin
            per_t e;
            e.len = PERIOD;
            e.high = high;
            e.mask = mask;
            e.stat = stat;
            e.name = name;
            exp_q.push_back(e);
            wait_ps();
        end
    endtask

    initial begin
        int n0;
        int n1;
        // Reset with all outputs enabled static: out must still read zero.
        en_out = 16'hFFFF;
        en_pwm = 16'h0000;
        duty = 8'h00;
        step(3);
        push_samp(cyc + 1, 16'h0000, 1'b0, 1'b1, 1'b1, "reset_state");
        step(2);

        // Release, static enable latency, disable latency, first period_start timing.
        rst_n = 1'b1;
        n0 = cyc;
        push_samp(n0 + 1, 16'h0000, 1'b0, 1'b1, 1'b0, "release_edge");
        push_samp(n0 + 2, 16'hFFFF, 1'b0, 1'b1, 1'b1, "static_on");
        step(10);
        push_samp(cyc + 1, 16'hFFFF, 1'b0, 1'b1, 1'b0, "static_hold");
        en_out = 16'h0000;
        push_samp(cyc + 1, 16'hFFFF, 1'b0, 1'b1, 1'b0, "off_latency");
        push_samp(cyc + 2, 16'h0000, 1'b0, 1'b1, 1'b0, "static_off");
        push_samp(n0 + PERIOD + 1, 16'h0000, 1'b0, 1'b0, 1'b1, "ps_before_first");
        push_samp(n0 + PERIOD + 2, 16'h0000, 1'b1, 1'b0, 1'b1, "ps_first");
        wait_ps();

        // 50% duty on the low byte, high byte disabled.
        en_out = 16'h00FF;
        en_pwm = 16'h00FF;
        duty = 8'h80;
        wait_ps();
        expect_periods(2, 512, 16'h00FF, 16'h0000, "duty_80");

        // Duty extremes.
        duty = 8'h00;
        wait_ps();
        expect_periods(1, 0, 16'h00FF, 16'h0000, "duty_00");
        duty = 8'hFF;
        wait_ps();
        expect_periods(3, PERIOD, 16'h00FF, 16'h0000, "duty_ff");

        // Mid-period duty change only lands at the next period.
        duty = 8'h40;
        wait_ps();
        begin
            per_t e;
            e.len = PERIOD;
            e.high = 256;
            e.mask = 16'h00FF;
            e.stat = 16'h0000;
            e.name = "change_cur";
            exp_q.push_back(e);
        end
        step(16 * DIV);
        duty = 8'hC0;
        wait_ps();
        expect_periods(1, 768, 16'h00FF, 16'h0000, "change_next");

        // Mixed static and PWM channels.
        en_out = 16'hFFFF;
        en_pwm = 16'hF0F0;
        duty = 8'h40;
        wait_ps();
        expect_periods(1, 256, 16'hF0F0, 16'h0F0F, "mixed");

        // Reset mid-period at counter 0x90.
        en_out = 16'h00FF;
        en_pwm = 16'h00FF;
        duty = 8'hFF;
        wait_ps();
        expect_periods(1, PERIOD, 16'h00FF, 16'h0000, "pre_reset_ff");
        step(16'h90 * DIV - 1);
        push_samp(cyc + 1, 16'h00FF, 1'b0, 1'b1, 1'b0, "pre_reset_high");
        step(1);
        rst_n = 1'b0;
        push_samp(cyc + 1, 16'h0000, 1'b0, 1'b1, 1'b1, "async_reset");
        step(3);
        rst_n = 1'b1;
        n1 = cyc;
        push_samp(n1 + 10, 16'h0000, 1'b0, 1'b1, 1'b0, "no_shadow_carry");
        push_samp(n1 + PERIOD + 1, 16'h0000, 1'b0, 1'b0, 1'b1, "ps_before_restart");
        push_samp(n1 + PERIOD + 2, 16'h0000, 1'b1, 1'b0, 1'b1, "ps_restart");
        wait_ps();
        step(2);

        if (samp_q.size() != 0 || exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL pending_checks: %0d sample and %0d period checks left, expected 0",
                     samp_q.size(), exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
